// File: rtl/hfu_pkg.sv
// hfu_pkg: shared definitions for the hazard/forwarding controller.
//
// Contents:
//   FWD_RF / FWD_EXMEM / FWD_MEMWB  operand-mux select encodings
//                                   (2'b11 is reserved and never driven)
//   ENT_* / ent_*()                 bit layout of one pipeline entry:
//                                   [0] valid, [1] regwrite,
//                                   [2 +: reg_aw] dst, [reg_aw+2] memread
//   Keeping memread as the top bit lets the forwarding view of an entry
//   be the contiguous low slice [reg_aw+1:0].
package hfu_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam int ENT_VALID    = 0;
  localparam int ENT_REGWRITE = 1;
  localparam int ENT_DST      = 2;

  // Index of the memread bit for a given register address width.
  function automatic int ent_memread(input int reg_aw);
    return reg_aw + ENT_DST;
  endfunction

  // Total entry width for a given register address width.
  function automatic int ent_width(input int reg_aw);
    return reg_aw + ENT_DST + 1;
  endfunction

endpackage

// File: rtl/hfu_src_match.sv
// hfu_src_match: per-operand producer search against the EX and MEM entries.
//
// Ports:
//   id_valid  in   ID holds a real instruction
//   src       in   source register address of this operand
//   used      in   operand is actually read
//   ex_ent    in   full EX entry (layout from hfu_pkg)
//   mem_ent   in   forwarding view of the MEM entry (valid/regwrite/dst only)
//   sel       out  select this operand gets when it enters EX next cycle
//   load_hit  out  operand depends on a load currently in EX
module hfu_src_match
  import hfu_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic                            id_valid,
  input  logic [REG_AW-1:0]               src,
  input  logic                            used,
  input  logic [ent_width(REG_AW)-1:0]    ex_ent,
  input  logic [ent_memread(REG_AW)-1:0]  mem_ent,
  output logic [1:0]                      sel,
  output logic                            load_hit
);

  logic live;
  logic hit_ex;
  logic hit_mem;

  // r0 is hard-wired zero: it never forwards and never stalls.
  assign live = id_valid & used & (src != '0);

  assign hit_ex = live & ex_ent[ENT_VALID] & ex_ent[ENT_REGWRITE]
                & (ex_ent[ENT_DST +: REG_AW] == src);

  assign hit_mem = live & mem_ent[ENT_VALID] & mem_ent[ENT_REGWRITE]
                 & (mem_ent[ENT_DST +: REG_AW] == src);

  // The EX entry is the younger producer, so it takes priority.
  always_comb begin
    sel = FWD_RF;
    if (hit_ex) begin
      sel = FWD_EXMEM;
    end else if (hit_mem) begin
      sel = FWD_MEMWB;
    end
  end

  assign load_hit = hit_ex & ex_ent[ent_memread(REG_AW)];

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: clocked hazard and forwarding controller for a
// 5-stage pipeline. Tracks in-flight writers, registers per-operand
// forwarding selects into EX, requests load-use stalls and freezes the
// pipeline while a load in MEM waits on data memory.
//
// Optional feature macro: HFU_PERF_EN (live load-use stall counter).
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   id_valid     ID holds a real instruction
//   id_src       source addresses, operand s at [s*REG_AW +: REG_AW]
//   id_src_used  per-operand "is read" bits
//   id_dst       destination register
//   id_regwrite  instruction writes id_dst
//   id_memread   instruction is a load
//   mem_ready    data memory has returned load data
//   stall_id     hold PC and IF/ID, bubble into EX (combinational)
//   freeze       hold every pipeline register (combinational)
//   ex_fwd_sel   registered per-operand selects for the instruction in EX
//   stall_cnt    saturating load-use stall count (0 without HFU_PERF_EN)
//
// Memory handshake: a load in MEM completes in the first cycle mem_ready
// is high; every cycle before that the whole pipeline is frozen. mem_ready
// is ignored when MEM does not hold a valid load.
module hazard_forward_unit
  import hfu_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src,
  input  logic [NUM_SRC-1:0]          id_src_used,
  input  logic [REG_AW-1:0]           id_dst,
  input  logic                        id_regwrite,
  input  logic                        id_memread,
  input  logic                        mem_ready,
  output logic                        stall_id,
  output logic                        freeze,
  output logic [2*NUM_SRC-1:0]        ex_fwd_sel,
  output logic [CNT_W-1:0]            stall_cnt
);

  localparam int EW = ent_width(REG_AW);
  localparam int MR = ent_memread(REG_AW);

  // The WB stage is not stored: the register file writes before it is
  // read, so a retiring writer needs no forwarding or hazard tracking.
  logic [EW-1:0]          ex_ent;
  logic [EW-1:0]          mem_ent;
  logic [EW-1:0]          id_ent;
  logic [2*NUM_SRC-1:0]   next_sel;
  logic [NUM_SRC-1:0]     load_hit;
  logic                   bubble;

  assign id_ent = {id_memread, id_dst, id_regwrite, id_valid};

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    hfu_src_match #(
      .REG_AW (REG_AW)
    ) u_match (
      .id_valid (id_valid),
      .src      (id_src[s*REG_AW +: REG_AW]),
      .used     (id_src_used[s]),
      .ex_ent   (ex_ent),
      .mem_ent  (mem_ent[MR-1:0]),
      .sel      (next_sel[2*s +: 2]),
      .load_hit (load_hit[s])
    );
  end

  assign freeze   = mem_ent[ENT_VALID] & mem_ent[MR] & ~mem_ready;
  // Freeze wins; a masked stall is re-evaluated once the freeze lifts.
  assign stall_id = (|load_hit) & ~freeze;
  assign bubble   = stall_id | ~id_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ent     <= '0;
      mem_ent    <= '0;
      ex_fwd_sel <= '0;
    end else if (!freeze) begin
      mem_ent <= ex_ent;
      if (bubble) begin
        ex_ent     <= '0;
        ex_fwd_sel <= '0;
      end else begin
        ex_ent     <= id_ent;
        ex_fwd_sel <= next_sel;
      end
    end
  end

`ifdef HFU_PERF_EN
  logic [CNT_W-1:0] cnt;

  // stall_id is already masked by freeze, so a frozen cycle never counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (stall_id && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign stall_cnt = cnt;
`else
  assign stall_cnt = '0;
`endif

endmodule
